// File: rtl/botupdt_snapshot_queue_pkg.sv
// Shared types for the rojobot update snapshot queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package botupdt_snapshot_queue_pkg;

    localparam int SNAP_W = 32;

    // One rojobot register snapshot; field order matches the CPU-visible word.
    typedef struct packed {
        logic [7:0] locx;
        logic [7:0] locy;
        logic [7:0] sensors;
        logic [7:0] botinfo;
    } bot_snap_t;

endpackage : botupdt_snapshot_queue_pkg

// File: rtl/botupdt_snapshot_queue_if.sv
// Bundle between rojobot/CPU side (master) and the snapshot queue (slave).
// Latency: n/a (wires only).
// Backpressure: none; the queue absorbs or drops updates, it never stalls the bot.
interface botupdt_snapshot_queue_if
    import botupdt_snapshot_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OVR_W = 8
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              i_upd_sysregs;
    logic [7:0]        i_locx;
    logic [7:0]        i_locy;
    logic [7:0]        i_sensors;
    logic [7:0]        i_botinfo;
    logic              i_int_ack;
    logic [SNAP_W-1:0] o_bot_info;
    logic              o_bot_updt;
    logic [LVL_W-1:0]  o_level;
    logic              o_overflow;
    logic [OVR_W-1:0]  o_ovr_cnt;

    modport master (
        output i_upd_sysregs, i_locx, i_locy, i_sensors, i_botinfo, i_int_ack,
        input  o_bot_info, o_bot_updt, o_level, o_overflow, o_ovr_cnt
    );

    modport slave (
        input  i_upd_sysregs, i_locx, i_locy, i_sensors, i_botinfo, i_int_ack,
        output o_bot_info, o_bot_updt, o_level, o_overflow, o_ovr_cnt
    );

endinterface : botupdt_snapshot_queue_if

// File: rtl/botupdt_snapshot_queue_fifo.sv
// Generic synchronous FIFO with a registered head output.
// Latency: a push into an empty FIFO appears on dout the next cycle.
// Backpressure: push while full is accepted only with a same-cycle pop; otherwise ignored.
module botupdt_snapshot_queue_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [W-1:0]     dout_q, dout_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign dout  = dout_q;

    // Next-state: array write, pointer/level update, and look-ahead of the new head.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        dout_d   = dout_q;
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        // Head is read from the post-write array so a push into an empty queue
        // (or into a draining level-1 queue) is visible one cycle later; an
        // emptied queue keeps showing the last popped word.
        if (level_d != '0) begin
            dout_d = mem_d[rd_ptr_d];
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            dout_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            dout_q   <= dout_d;
        end
    end

endmodule : botupdt_snapshot_queue_fifo

// File: rtl/botupdt_snapshot_queue.sv
// Queues rojobot register snapshots for the CPU and raises a level interrupt while any are pending.
// Latency: 1 cycle from update edge to o_bot_updt/o_bot_info.
// Backpressure: none toward the bot; updates arriving at a full queue are dropped and counted.
module botupdt_snapshot_queue
    import botupdt_snapshot_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OVR_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    botupdt_snapshot_queue_if.slave   bus
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             upd_prev_q, upd_prev_d;
    logic             ack_prev_q, ack_prev_d;
    logic             bot_updt_q, bot_updt_d;
    logic             overflow_q, overflow_d;
    logic [OVR_W-1:0] ovr_cnt_q, ovr_cnt_d;
    logic             upd_evt;
    logic             ack_evt;
    logic             push;
    logic             pop;
    logic             drop;
    bot_snap_t        snap;
    logic [SNAP_W-1:0] fifo_dout;
    logic [LVL_W-1:0] fifo_level;
    logic             fifo_full;
    logic             fifo_empty;

    // Data is captured straight from the bot registers in the edge cycle.
    assign snap = '{locx: bus.i_locx, locy: bus.i_locy,
                    sensors: bus.i_sensors, botinfo: bus.i_botinfo};

    botupdt_snapshot_queue_fifo #(
        .DEPTH (DEPTH),
        .W     (SNAP_W),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (snap),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Edge detection, push/pop/drop decisions and sticky overflow accounting.
    always_comb begin
        upd_prev_d = bus.i_upd_sysregs;
        ack_prev_d = bus.i_int_ack;
        upd_evt    = bus.i_upd_sysregs & ~upd_prev_q;
        ack_evt    = bus.i_int_ack & ~ack_prev_q;
        pop        = ack_evt & ~fifo_empty;
        // A same-cycle pop frees the slot, so a full queue still accepts the update.
        push       = upd_evt & (~fifo_full | pop);
        drop       = upd_evt & fifo_full & ~pop;
        overflow_d = overflow_q | drop;
        ovr_cnt_d  = ovr_cnt_q;
        if (drop && !(&ovr_cnt_q)) begin
            ovr_cnt_d = ovr_cnt_q + 1'b1;
        end
        // Interrupt tracks the occupancy the queue will have after this edge.
        bot_updt_d = push | (fifo_level > LVL_W'(1)) | ((fifo_level == LVL_W'(1)) & ~pop);
    end

    // Registers; prev flops reset high so a level already present at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_prev_q <= 1'b1;
            ack_prev_q <= 1'b1;
            bot_updt_q <= 1'b0;
            overflow_q <= 1'b0;
            ovr_cnt_q  <= '0;
        end else begin
            upd_prev_q <= upd_prev_d;
            ack_prev_q <= ack_prev_d;
            bot_updt_q <= bot_updt_d;
            overflow_q <= overflow_d;
            ovr_cnt_q  <= ovr_cnt_d;
        end
    end

    assign bus.o_bot_info = fifo_dout;
    assign bus.o_bot_updt = bot_updt_q;
    assign bus.o_level    = fifo_level;
    assign bus.o_overflow = overflow_q;
    assign bus.o_ovr_cnt  = ovr_cnt_q;

endmodule : botupdt_snapshot_queue

// File: tb/tb_botupdt_snapshot_queue.sv
// Self-checking bench for the snapshot queue using a snapshot scoreboard.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: exercises full, overflow, saturation and simultaneous push/pop.
module tb_botupdt_snapshot_queue;
    import botupdt_snapshot_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int OVR_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    botupdt_snapshot_queue_if #(.DEPTH(DEPTH), .OVR_W(OVR_W)) bus ();

    botupdt_snapshot_queue #(.DEPTH(DEPTH), .OVR_W(OVR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int        n_chk  = 0;
    int        n_fail = 0;
    bot_snap_t sb[$];
    int        m_ovr  = 0;
    logic      m_ovf  = 1'b0;
    logic [31:0] m_info = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".level"}, 32'(bus.o_level), 32'(sb.size()));
        chk({tag, ".updt"},  32'(bus.o_bot_updt), 32'(sb.size() != 0));
        chk({tag, ".info"},  bus.o_bot_info, m_info);
        chk({tag, ".ovf"},   32'(bus.o_overflow), 32'(m_ovf));
        chk({tag, ".cnt"},   32'(bus.o_ovr_cnt), 32'(m_ovr));
    endtask

    task automatic set_data(input bot_snap_t d);
        bus.i_locx    = d.locx;
        bus.i_locy    = d.locy;
        bus.i_sensors = d.sensors;
        bus.i_botinfo = d.botinfo;
    endtask

    task automatic model_push(input bot_snap_t d);
        if (sb.size() < DEPTH) begin
            sb.push_back(d);
        end else begin
            m_ovf = 1'b1;
            if (m_ovr < 255) m_ovr++;
        end
        if (sb.size() != 0) m_info = sb[0];
    endtask

    // Update pulse: one cycle high, one cycle low; checks the cycle after the edge.
    task automatic upd_pulse(input bot_snap_t d, input string tag, input bit do_chk);
        set_data(d);
        bus.i_upd_sysregs = 1'b1;
        tick();
        model_push(d);
        if (do_chk) check_state(tag);
        bus.i_upd_sysregs = 1'b0;
        tick();
    endtask

    // Ack pulse: compares the visible head with the scoreboard before popping it.
    task automatic ack_pulse(input string tag);
        bot_snap_t exp_head;
        if (sb.size() != 0) begin
            exp_head = sb.pop_front();
            chk({tag, ".head"}, bus.o_bot_info, exp_head);
        end
        bus.i_int_ack = 1'b1;
        tick();
        if (sb.size() != 0) m_info = sb[0];
        check_state(tag);
        bus.i_int_ack = 1'b0;
        tick();
    endtask

    initial begin
        bot_snap_t d;
        bot_snap_t exp_head;
        bus.i_upd_sysregs = 1'b1;
        bus.i_int_ack     = 1'b1;
        set_data('{8'hAA, 8'hBB, 8'hCC, 8'hDD});

        // 1: reset release with both strobes already high produces no event
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check_state("rst_rel");
        bus.i_upd_sysregs = 1'b0;
        bus.i_int_ack     = 1'b0;
        tick();

        // 2: single update then ack
        upd_pulse('{8'h12, 8'h34, 8'h56, 8'h78}, "single_upd", 1'b1);
        chk("single_info", bus.o_bot_info, 32'h12345678);
        ack_pulse("single_ack");
        chk("hold_info", bus.o_bot_info, 32'h12345678);

        // 3: five updates into a 4-deep queue; the fifth is dropped
        for (int n = 1; n <= 5; n++) begin
            d = '{8'(n), 8'(n + 16), 8'(n + 32), 8'(n + 48)};
            upd_pulse(d, $sformatf("burst%0d", n), 1'b1);
        end
        chk("burst_cnt", 32'(bus.o_ovr_cnt), 32'd1);
        for (int n = 1; n <= 4; n++) ack_pulse($sformatf("drain%0d", n));

        // 4: full queue, update and ack rising together
        for (int n = 0; n < 4; n++) upd_pulse('{8'hA0 + 8'(n), 8'h01, 8'h02, 8'h03}, "fill4", 1'b0);
        check_state("full4");
        d = '{8'hC5, 8'hC6, 8'hC7, 8'hC8};
        exp_head = sb.pop_front();
        chk("simul.head", bus.o_bot_info, exp_head);
        set_data(d);
        bus.i_upd_sysregs = 1'b1;
        bus.i_int_ack     = 1'b1;
        tick();
        model_push(d);
        check_state("simul");
        bus.i_upd_sysregs = 1'b0;
        bus.i_int_ack     = 1'b0;
        tick();
        for (int n = 0; n < 4; n++) ack_pulse($sformatf("simul_drain%0d", n));

        // 5: held ack pops once; ack on empty is ignored
        upd_pulse('{8'h51, 8'h52, 8'h53, 8'h54}, "hold_a", 1'b0);
        upd_pulse('{8'h61, 8'h62, 8'h63, 8'h64}, "hold_b", 1'b0);
        exp_head = sb.pop_front();
        chk("held.head", bus.o_bot_info, exp_head);
        bus.i_int_ack = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        m_info = sb[0];
        check_state("held_ack");
        bus.i_int_ack = 1'b0;
        tick();
        ack_pulse("held_last");
        ack_pulse("empty_ack");

        // 6: saturate the overrun counter, then reset mid-burst
        for (int n = 0; n < 4; n++) upd_pulse('{8'hE0 + 8'(n), 8'h00, 8'h00, 8'h00}, "sat_fill", 1'b0);
        for (int n = 0; n < 300; n++) upd_pulse('{8'hF0, 8'(n), 8'h00, 8'h00}, "sat", 1'b0);
        check_state("saturated");
        chk("sat_cnt", 32'(bus.o_ovr_cnt), 32'hFF);
        set_data('{8'h99, 8'h99, 8'h99, 8'h99});
        bus.i_upd_sysregs = 1'b1;
        bus.i_int_ack     = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        m_ovr  = 0;
        m_ovf  = 1'b0;
        m_info = '0;
        check_state("mid_rst");
        tick();
        check_state("post_rst_level");
        bus.i_upd_sysregs = 1'b0;
        bus.i_int_ack     = 1'b0;
        tick();
        upd_pulse('{8'h0F, 8'h1E, 8'h2D, 8'h3C}, "post_rst_upd", 1'b1);
        ack_pulse("post_rst_ack");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule : tb_botupdt_snapshot_queue
